// File: rtl/mycpu_pkg.sv
// mycpu_pkg -- shared ALU definitions.
//   alu_op_t   : 4-bit operation codes (10-15 are illegal)
//   alu_st_t   : ALU control states
//   FLAG_*     : bit positions inside the {C,N,Z} flag vector
//   DW_DEFAULT : default datapath width
package mycpu_pkg;

  localparam int DW_DEFAULT = 16;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_PASS = 4'd8,
    OP_MUL  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_st_t;

endpackage

// File: rtl/alu_mul.sv
// alu_mul -- iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : latch a/b and begin (ignored by design while busy)
//   a, b      : unsigned DW-bit operands
//   busy      : iteration in progress (DW cycles after start)
//   done      : high in the final busy cycle; product is valid then
//   product   : full 2*DW-bit product (combinational, valid with done)
module alu_mul #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] product
);

  localparam int CW = $clog2(DW);

  logic [2*DW-1:0] mcand_q;
  logic [DW-1:0]   mplier_q;
  logic [2*DW-1:0] acc_q;
  logic [2*DW-1:0] acc_nxt;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            last;

  assign last    = (cnt_q == CW'(DW - 1));
  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  // The final partial product is folded in combinationally so the caller
  // can register the product on the same edge the iteration ends.
  assign busy    = busy_q;
  assign done    = busy_q && last;
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start && !busy_q) begin
      mcand_q  <= {{DW{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (last) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu.sv
// alu -- register-bank ALU with single-cycle ops and an optional
// iterative multiplier.
// Configuration: define ALU_MUL_EN to enable op 9 (MUL) and instantiate
// alu_mul; without it op 9 is illegal and busy_out is tied low.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start_in, op_in   : operation request and code (alu_op_t)
//   a_in, b_in        : operands from register-bank ports A/B
//   y_out             : registered result (register-bank write data)
//   done_out          : one-cycle completion pulse (write enable)
//   busy_out          : multiply in progress
//   flags_out         : registered {C,N,Z}
//   err_out           : pulses with done_out for an illegal op
module alu
  import mycpu_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_in,
  input  logic [3:0]    op_in,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] y_out,
  output logic          done_out,
  output logic          busy_out,
  output logic [2:0]    flags_out,
  output logic          err_out
);

  alu_st_t       state, state_nxt;
  logic          accept;
  logic          is_mul;
  logic          legal;
  logic          carry;
  logic [DW-1:0] res;
  logic          err_q;

  function automatic logic [2:0] pack_flags(input logic c, input logic [DW-1:0] y);
    logic [2:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = y[DW-1];
    f[FLAG_Z] = (y == '0);
    return f;
  endfunction

  // Requests arriving mid-multiply are dropped, not queued.
  assign accept = start_in && (state != ST_MUL);

`ifdef ALU_MUL_EN
  logic          mul_busy;
  logic          mul_done;
  logic [2*DW-1:0] mul_prod;

  assign is_mul   = (op_in == OP_MUL);
  assign busy_out = (state == ST_MUL);

  alu_mul #(.DW(DW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a_in),
    .b       (b_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign busy_out = 1'b0;
`endif

  // Single-cycle datapath; the extra MSB of ADD/SUB is carry/borrow.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    legal = 1'b1;
    case (op_in)
      OP_ADD:  {carry, res} = {1'b0, a_in} + {1'b0, b_in};
      OP_SUB:  {carry, res} = {1'b0, a_in} - {1'b0, b_in};
      OP_AND:  res = a_in & b_in;
      OP_OR:   res = a_in | b_in;
      OP_XOR:  res = a_in ^ b_in;
      OP_NOT:  res = ~a_in;
      OP_SHL:  begin res = a_in << 1; carry = a_in[DW-1]; end
      OP_SHR:  begin res = a_in >> 1; carry = a_in[0];    end
      OP_PASS: res = b_in;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_nxt = is_mul ? ST_MUL : ST_DONE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        if (mul_done) begin
          state_nxt = ST_DONE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign done_out = (state == ST_DONE);
  assign err_out  = done_out && err_q;

  // Result/flag registers: written only on a completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_out     <= '0;
      flags_out <= '0;
      err_q     <= 1'b0;
    end else if (accept && !is_mul) begin
      y_out <= legal ? res : '0;
      err_q <= !legal;
      if (legal) begin
        flags_out <= pack_flags(carry, res);
      end
    end
`ifdef ALU_MUL_EN
    else if ((state == ST_MUL) && mul_done) begin
      y_out     <= mul_prod[DW-1:0];
      err_q     <= 1'b0;
      flags_out <= pack_flags(|mul_prod[2*DW-1:DW], mul_prod[DW-1:0]);
    end
`endif
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed self-checking bench for alu (default build, plus MUL
// sequences when ALU_MUL_EN is defined).
module tb_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic [3:0]  op_in = 4'd0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [15:0] y_out;
  logic        done_out;
  logic        busy_out;
  logic [2:0]  flags_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;

  alu #(.DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .op_in     (op_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .y_out     (y_out),
    .done_out  (done_out),
    .busy_out  (busy_out),
    .flags_out (flags_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, take one edge, land 1ns after it; start stays high.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // flags are {C,N,Z}
  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y_out, 16'h0000);
    chk("rst_flags", flags_out, 3'b000);
    chk("rst_done", done_out, 1'b0);
    chk("rst_err", err_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ADD wrap-around, then SUB and SHR back-to-back
    issue(4'd0, 16'hFFFF, 16'h0001);
    chk("add_y", y_out, 16'h0000);
    chk("add_done", done_out, 1'b1);
    chk("add_flags", flags_out, 3'b101);
    chk("add_err", err_out, 1'b0);
    issue(4'd1, 16'h0003, 16'h0005);
    chk("sub_y", y_out, 16'hFFFE);
    chk("sub_done", done_out, 1'b1);
    chk("sub_flags", flags_out, 3'b110);
    issue(4'd7, 16'h0001, 16'h0000);
    chk("shr_y", y_out, 16'h0000);
    chk("shr_done", done_out, 1'b1);
    chk("shr_flags", flags_out, 3'b101);
    idle_cycle();
    chk("idle_done", done_out, 1'b0);
    chk("idle_y_hold", y_out, 16'h0000);
    chk("idle_flags_hold", flags_out, 3'b101);

    // remaining single-cycle ops
    issue(4'd8, 16'hDEAD, 16'h1234);
    chk("pass_y", y_out, 16'h1234);
    chk("pass_flags", flags_out, 3'b000);
    issue(4'd2, 16'hF0F0, 16'h0FF0);
    chk("and_y", y_out, 16'h00F0);
    issue(4'd3, 16'hF000, 16'h000F);
    chk("or_y", y_out, 16'hF00F);
    chk("or_flags", flags_out, 3'b010);
    issue(4'd4, 16'hAAAA, 16'hAAAA);
    chk("xor_y", y_out, 16'h0000);
    chk("xor_flags", flags_out, 3'b001);
    issue(4'd5, 16'h0000, 16'h5555);
    chk("not_y", y_out, 16'hFFFF);
    chk("not_flags", flags_out, 3'b010);
    issue(4'd6, 16'h8001, 16'h0000);
    chk("shl_y", y_out, 16'h0002);
    chk("shl_flags", flags_out, 3'b100);

    // illegal op 12 after y=0x1234 with C set
    issue(4'd1, 16'h1233, 16'hFFFF);
    chk("sub2_y", y_out, 16'h1234);
    chk("sub2_flags", flags_out, 3'b100);
    issue(4'd12, 16'h1111, 16'h2222);
    chk("ill_y", y_out, 16'h0000);
    chk("ill_done", done_out, 1'b1);
    chk("ill_err", err_out, 1'b1);
    chk("ill_flags", flags_out, 3'b100);
    idle_cycle();
    chk("ill_err_pulse", err_out, 1'b0);
    chk("ill_done_pulse", done_out, 1'b0);

`ifndef ALU_MUL_EN
    // op 9 is illegal when the multiplier is not built
    issue(4'd1, 16'h1233, 16'hFFFF);
    issue(4'd9, 16'h0100, 16'h0101);
    chk("op9_y", y_out, 16'h0000);
    chk("op9_done", done_out, 1'b1);
    chk("op9_err", err_out, 1'b1);
    chk("op9_flags", flags_out, 3'b100);
    chk("op9_busy", busy_out, 1'b0);
    idle_cycle();
`else
    // MUL 0x0100*0x0101 = 0x0001_0100 with start pulses during busy
    issue(4'd8, 16'h0000, 16'h00AA);
    issue(4'd9, 16'h0100, 16'h0101);
    chk("mul_busy_1", busy_out, 1'b1);
    chk("mul_nodone_1", done_out, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      start_in = (i >= 4 && i <= 6);
      op_in    = 4'd0;
      @(posedge clk);
      #1;
      chk($sformatf("mul_busy_%0d", i), busy_out, 1'b1);
      chk($sformatf("mul_nodone_%0d", i), done_out, 1'b0);
      chk($sformatf("mul_yhold_%0d", i), y_out, 16'h00AA);
    end
    idle_cycle();
    chk("mul_done", done_out, 1'b1);
    chk("mul_busy_end", busy_out, 1'b0);
    chk("mul_y", y_out, 16'h0100);
    chk("mul_flags", flags_out, 3'b100);
    chk("mul_err", err_out, 1'b0);
    idle_cycle();
    chk("mul_done_pulse", done_out, 1'b0);

    // reset five cycles into a multiply
    issue(4'd9, 16'h0100, 16'h0101);
    @(negedge clk);
    start_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_pre", busy_out, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_y", y_out, 16'h0000);
    chk("abort_flags", flags_out, 3'b000);
    chk("abort_busy", busy_out, 1'b0);
    chk("abort_done", done_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (20) begin
        @(posedge clk);
        #1;
        seen = seen | done_out;
      end
      chk("abort_no_done", seen, 1'b0);
    end
    issue(4'd0, 16'h0002, 16'h0003);
    chk("abort_add_y", y_out, 16'h0005);
    idle_cycle();
`endif

    // reset wins over a simultaneous start
    issue(4'd8, 16'h0000, 16'h00FF);
    chk("pre_rst_y", y_out, 16'h00FF);
    @(negedge clk);
    rst      = 1'b1;
    start_in = 1'b1;
    op_in    = 4'd0;
    a_in     = 16'h0001;
    b_in     = 16'h0001;
    @(posedge clk);
    #1;
    chk("rstprio_y", y_out, 16'h0000);
    chk("rstprio_done", done_out, 1'b0);
    chk("rstprio_flags", flags_out, 3'b000);
    @(negedge clk);
    rst      = 1'b0;
    start_in = 1'b0;
    issue(4'd0, 16'h0002, 16'h0003);
    chk("add23_y", y_out, 16'h0005);
    chk("add23_done", done_out, 1'b1);
    chk("add23_flags", flags_out, 3'b000);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
